// File: rtl/truth_table_sweeper.sv
// Exhaustive on-board self-test for a combinational DUT. Walks every input vector
// in binary order, captures f for each one and scores the result against a golden table.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2**N_IN-1:0]    expected,
    output logic [N_IN-1:0]       dut_in,
    input  logic                  dut_f,
    output logic                  busy,
    output logic                  done,
    output logic [2**N_IN-1:0]    captured,
    output logic [N_IN:0]         mismatch_count,
    output logic [N_IN-1:0]       first_fail_idx,
    output logic                  pass
);

    localparam int unsigned TW   = 2**N_IN;
    localparam int unsigned CW   = N_IN + 1;
    localparam int unsigned SW   = (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);
    localparam int unsigned LAST = TW - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [N_IN-1:0]   idx, idx_nxt;
    logic [SW-1:0]     cnt, cnt_nxt;
    logic [TW-1:0]     exp_q, exp_nxt;
    logic [N_IN-1:0]   dut_in_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic [TW-1:0]     captured_nxt;
    logic [CW-1:0]     mm_nxt;
    logic [N_IN-1:0]   ff_nxt;
    logic              pass_nxt;

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            exp_q          <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            captured       <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            cnt            <= cnt_nxt;
            exp_q          <= exp_nxt;
            dut_in         <= dut_in_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            captured       <= captured_nxt;
            mismatch_count <= mm_nxt;
            first_fail_idx <= ff_nxt;
            pass           <= pass_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        cnt_nxt      = cnt;
        exp_nxt      = exp_q;
        dut_in_nxt   = dut_in;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        captured_nxt = captured;
        mm_nxt       = mismatch_count;
        ff_nxt       = first_fail_idx;
        pass_nxt     = pass;

        unique case (state)
            IDLE: begin
                dut_in_nxt = '0;
                busy_nxt   = 1'b0;
                if (start) begin
                    state_nxt    = RUN;
                    exp_nxt      = expected;
                    captured_nxt = '0;
                    mm_nxt       = '0;
                    ff_nxt       = '0;
                    pass_nxt     = 1'b0;
                    idx_nxt      = '0;
                    cnt_nxt      = SW'(SETTLE);
                    busy_nxt     = 1'b1;
                end
            end

            RUN: begin
                if (abort) begin
                    state_nxt    = IDLE;
                    busy_nxt     = 1'b0;
                    dut_in_nxt   = '0;
                    captured_nxt = '0;
                    mm_nxt       = '0;
                    ff_nxt       = '0;
                    pass_nxt     = 1'b0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - SW'(1);
                end else begin
                    captured_nxt[idx] = dut_f;
                    if (dut_f != exp_q[idx]) begin
                        mm_nxt = mismatch_count + CW'(1);
                        if (mismatch_count == '0) begin
                            ff_nxt = idx;
                        end
                    end
                    // The final sample and the DONE entry share one edge, so pass uses the updated count
                    if (idx == N_IN'(LAST)) begin
                        state_nxt  = DONE;
                        busy_nxt   = 1'b0;
                        dut_in_nxt = '0;
                        done_nxt   = 1'b1;
                        pass_nxt   = (mm_nxt == '0);
                    end else begin
                        idx_nxt    = idx + N_IN'(1);
                        dut_in_nxt = idx + N_IN'(1);
                        cnt_nxt    = SW'(SETTLE);
                    end
                end
            end

            DONE: begin
                state_nxt  = IDLE;
                busy_nxt   = 1'b0;
                dut_in_nxt = '0;
            end

            default: begin
                state_nxt  = IDLE;
                busy_nxt   = 1'b0;
                dut_in_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (SETTLE=2 and SETTLE=0)
// each driving a 4-input parity mock.
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        st;
    logic        ab;
    logic        sel0;
    logic [15:0] exp_in;

    logic        start2, abort2, start0, abort0;
    logic [3:0]  dut_in2, dut_in0;
    logic        f2, f0;
    logic        busy2, busy0, done2, done0, pass2, pass0;
    logic [15:0] cap2, cap0;
    logic [4:0]  mm2, mm0;
    logic [3:0]  ff2, ff0;

    logic [3:0]  m_dut_in;
    logic        m_busy, m_done, m_pass;
    logic [15:0] m_cap;
    logic [4:0]  m_mm;
    logic [3:0]  m_ff;

    int vectors;
    int miscompares;

    assign start2 = st & ~sel0;
    assign abort2 = ab & ~sel0;
    assign start0 = st & sel0;
    assign abort0 = ab & sel0;
    assign f2     = ^dut_in2;
    assign f0     = ^dut_in0;

    assign m_dut_in = sel0 ? dut_in0 : dut_in2;
    assign m_busy   = sel0 ? busy0   : busy2;
    assign m_done   = sel0 ? done0   : done2;
    assign m_pass   = sel0 ? pass0   : pass2;
    assign m_cap    = sel0 ? cap0    : cap2;
    assign m_mm     = sel0 ? mm0     : mm2;
    assign m_ff     = sel0 ? ff0     : ff2;

    truth_table_sweeper #(.N_IN(4), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .expected(exp_in),
        .dut_in(dut_in2), .dut_f(f2), .busy(busy2), .done(done2), .captured(cap2),
        .mismatch_count(mm2), .first_fail_idx(ff2), .pass(pass2)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(exp_in),
        .dut_in(dut_in0), .dut_f(f0), .busy(busy0), .done(done0), .captured(cap0),
        .mismatch_count(mm0), .first_fail_idx(ff0), .pass(pass0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " busy"},   32'(m_busy),   32'd0);
        check({tag, " done"},   32'(m_done),   32'd0);
        check({tag, " dut_in"}, 32'(m_dut_in), 32'd0);
        check({tag, " cap"},    32'(m_cap),    32'd0);
        check({tag, " mm"},     32'(m_mm),     32'd0);
        check({tag, " ff"},     32'(m_ff),     32'd0);
        check({tag, " pass"},   32'(m_pass),   32'd0);
    endtask

    // Accept a start, then follow the sweep to its done pulse (bounded); optionally pulses start while busy.
    task automatic run_sweep(input logic [15:0] exp, input bit poke, input logic [15:0] exp_after,
                             output int lat, output bit seq_ok, output bit start_ok);
        int period;
        int total;
        period   = sel0 ? 1 : 3;
        total    = 16 * period;
        exp_in   = exp;
        st       = 1'b1;
        @(posedge clk); #1;
        st       = 1'b0;
        exp_in   = exp_after;
        start_ok = m_busy && (m_dut_in == 4'd0) && !m_done;
        lat      = 0;
        seq_ok   = 1'b1;
        for (int i = 1; i <= 200 && lat == 0; i++) begin
            @(posedge clk); #1;
            st = poke && (i < total - 2) && (i % 2 == 1);
            if (m_done) begin
                lat = i;
                if (m_busy || m_dut_in != 4'd0) seq_ok = 1'b0;
            end else if (!m_busy || m_dut_in != 4'(i / period)) begin
                seq_ok = 1'b0;
            end
        end
        st = 1'b0;
    endtask

    int  lat;
    bit  seq_ok;
    bit  start_ok;
    int  extra_done;
    bit  found;

    initial begin
        vectors     = 0;
        miscompares = 0;
        sel0        = 1'b0;
        ab          = 1'b0;
        exp_in      = 16'h6996;
        st          = 1'b1;
        rst_n       = 1'b0;

        // Reset held with start asserted: nothing moves
        repeat (4) @(posedge clk);
        #1;
        check_cleared("reset2");
        sel0 = 1'b1;
        #1;
        check_cleared("reset0");
        sel0 = 1'b0;
        st   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Matching table
        run_sweep(16'h6996, 1'b0, 16'h6996, lat, seq_ok, start_ok);
        check("match start",   32'(start_ok), 32'd1);
        check("match latency", 32'(lat),      32'd48);
        check("match dut_in",  32'(seq_ok),   32'd1);
        check("match cap",     32'(m_cap),    32'h6996);
        check("match mm",      32'(m_mm),     32'd0);
        check("match pass",    32'(m_pass),   32'd1);
        check("match ff",      32'(m_ff),     32'd0);
        @(posedge clk); #1;
        check("done width",    32'(m_done),   32'd0);
        check("result hold",   32'(m_pass),   32'd1);

        // Two flipped bits (5 and 8)
        run_sweep(16'h68B6, 1'b0, 16'h68B6, lat, seq_ok, start_ok);
        check("two latency",   32'(lat),      32'd48);
        check("two cap",       32'(m_cap),    32'h6996);
        check("two mm",        32'(m_mm),     32'd2);
        check("two ff",        32'(m_ff),     32'd5);
        check("two pass",      32'(m_pass),   32'd0);
        @(posedge clk); #1;

        // Fully inverted table; expected changes right after acceptance and must be ignored
        run_sweep(16'h9669, 1'b0, 16'h6996, lat, seq_ok, start_ok);
        check("inv latency",   32'(lat),      32'd48);
        check("inv mm",        32'(m_mm),     32'd16);
        check("inv ff",        32'(m_ff),     32'd0);
        check("inv pass",      32'(m_pass),   32'd0);
        @(posedge clk); #1;

        // start pulses during RUN are ignored
        run_sweep(16'h6996, 1'b1, 16'h6996, lat, seq_ok, start_ok);
        check("poke latency",  32'(lat),      32'd48);
        check("poke dut_in",   32'(seq_ok),   32'd1);
        extra_done = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (m_done) extra_done++;
        end
        check("poke extra done", 32'(extra_done), 32'd0);
        check("poke idle busy",  32'(m_busy),     32'd0);

        // Abort at vector 7
        exp_in = 16'h9669;
        st     = 1'b1;
        @(posedge clk); #1;
        st     = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_dut_in == 4'd7) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("abort reach7", 32'(found), 32'd1);
        check("abort pre mm", 32'(m_mm != 5'd0), 32'd1);
        ab = 1'b1;
        @(posedge clk); #1;
        ab = 1'b0;
        check_cleared("abort");
        extra_done = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (m_done) extra_done++;
        end
        check("abort no done", 32'(extra_done), 32'd0);

        // Asynchronous reset mid-sweep at vector 9
        exp_in = 16'h6996;
        st     = 1'b1;
        @(posedge clk); #1;
        st     = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_dut_in == 4'd9) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rst reach9", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_cleared("async rst");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep(16'h6996, 1'b0, 16'h6996, lat, seq_ok, start_ok);
        check("post rst latency", 32'(lat),    32'd48);
        check("post rst pass",    32'(m_pass), 32'd1);
        @(posedge clk); #1;

        // SETTLE=0 instance
        sel0 = 1'b1;
        #1;
        run_sweep(16'h6996, 1'b0, 16'h6996, lat, seq_ok, start_ok);
        check("s0 start",   32'(start_ok), 32'd1);
        check("s0 latency", 32'(lat),      32'd16);
        check("s0 dut_in",  32'(seq_ok),   32'd1);
        check("s0 cap",     32'(m_cap),    32'h6996);
        check("s0 pass",    32'(m_pass),   32'd1);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Drives a 4-input combinational DUT (inputs a,b,c,d; output f) through all 2^N_IN input combinations in binary order.
- Samples f once per vector, assembles the captured truth table, and compares it against an expected table.
- Reports pass/fail, the mismatch count and the first failing index.
- Replaces hand-written exhaustive stimulus blocks, so that any lab combinational function can be checked by a synthesizable on-board self-test.

## Interface
- N_IN, 4, number of DUT inputs; the table width is 2^N_IN.
- SETTLE, 2, extra cycles each vector is held before f is sampled (≥0).

- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- expected  input  2^N_IN  golden truth table; bit k = f for input value k; latched at start acceptance.
- dut_in  output  N_IN  registered stimulus to DUT; dut_in[N_IN-1]=a … dut_in[0]=d.
- dut_f  input  1  DUT output.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse at sweep completion.
- captured  output  2^N_IN  sampled truth table; bit k = dut_f seen for vector k.
- mismatch_count  output  N_IN+1  number of bits where captured ≠ expected.
- first_fail_idx  output  N_IN  lowest mismatching k; 0 when there is no mismatch.
- pass  output  1  high when the last completed sweep had mismatch_count==0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - dut_in=0, busy=0.
  - start=1 at an edge → latch expected; clear captured, mismatch_count, first_fail_idx and pass; set idx=0 and settle counter=SETTLE; go to RUN.
- RUN:
  - dut_in=idx, busy=1.
  - Settle counter decrements each cycle.
  - At the edge where the counter is 0:
    - captured[idx]←dut_f.
    - If dut_f≠expected_latched[idx]: mismatch_count+1, and first_fail_idx←idx if this is the first mismatch.
    - If idx=2^N_IN-1 → DONE; else idx+1 and counter reloads to SETTLE.
- DONE (one cycle):
  - done=1, busy=0, dut_in=0, pass=(mismatch_count==0).
  - Unconditionally → IDLE.
  - start is ignored in DONE and accepted from the following IDLE cycle.
- Results hold until the next accepted start.
- start while busy: ignored.
- abort=1 in RUN:
  - Next edge → IDLE.
  - No done pulse; captured, mismatch_count, first_fail_idx and pass cleared to 0.
  - abort has no effect in IDLE or DONE.
  - abort and start together in IDLE: start wins.
- Comparison uses the latched copy of expected; changing expected mid-sweep has no effect.
- Settle counter width is max(1, clog2(SETTLE+1)).
- idx wraps only through DONE, never back into RUN.

## Timing
- Reset (rst_n=0, async): state=IDLE; dut_in=0, busy=0, done=0, captured=0, mismatch_count=0, first_fail_idx=0, pass=0. Takes effect immediately, including mid-sweep.
- Start accepted at edge E0 → busy=1 and dut_in=0 from E0.
- Vector k is held for exactly SETTLE+1 cycles. It is sampled at edge E0+(SETTLE+1)(k+1).
- Last sample at edge E0+(SETTLE+1)·2^N_IN. The same edge enters DONE: done=1, busy=0, final results valid.
- Earliest next start is accepted 2 edges after the final sample.
- With defaults, done asserts 48 cycles after start acceptance.
- The DUT path from dut_in to dut_f must settle within SETTLE+1 cycles.

## Test plan
- Reset: hold rst_n=0 with start=1 → all outputs 0 and no sweep. Release, then pulse start → busy rises on the next edge.
- Parity mock (f=a^b^c^d), expected=16'h6996, SETTLE=2:
  - dut_in steps 0..15, each held 3 cycles.
  - done exactly 48 cycles after acceptance; captured=16'h6996, mismatch_count=0, pass=1, first_fail_idx=0.
- Parity mock, expected=16'h6996^16'h0120 → mismatch_count=2, first_fail_idx=5, pass=0, captured=16'h6996.
- Parity mock, expected=16'h9669 → mismatch_count=16, first_fail_idx=0, pass=0.
- start pulses during RUN are ignored: still exactly one done at 48 cycles. Then abort asserted while dut_in=7 → next edge busy=0, dut_in=0, no done, all results 0.
- rst_n pulsed low while dut_in=9 → outputs clear asynchronously. A new start then completes normally with pass=1; with SETTLE=0, done arrives 16 cycles after acceptance.
